// File: rtl/multicycle_pc_sequencer.sv
// multicycle_pc_sequencer: IF/ID/EXE/MEM/WB control FSM driving PC, IR, register-file and data-memory strobes
module multicycle_pc_sequencer #(
  parameter logic [5:0] OP_LW   = 6'b110001,
  parameter logic [5:0] OP_SW   = 6'b110000,
  parameter logic [5:0] OP_BEQ  = 6'b110100,
  parameter logic [5:0] OP_J    = 6'b111000,
  parameter logic [5:0] OP_HALT = 6'b111111,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWre,
  output logic [1:0]       pc_src,
  output logic             ir_wre,
  output logic             reg_wre,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;
  state_t cur, nxt;
  logic [5:0] op_q;
  logic id_j, exe_beq, in_mem, in_wb;
  assign id_j    = cur == S_ID && opcode == OP_J;
  assign exe_beq = cur == S_EXE && op_q == OP_BEQ;
  assign in_mem  = cur == S_MEM;
  assign in_wb   = cur == S_WB;
  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF:   nxt = S_ID;
      S_ID:   nxt = opcode == OP_J ? S_IF : opcode == OP_HALT ? S_HALT : S_EXE;
      S_EXE:  nxt = op_q == OP_BEQ ? S_IF : (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
      S_MEM:  nxt = !mem_ready ? S_MEM : op_q == OP_LW ? S_WB : S_IF;
      S_WB:   nxt = S_IF;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end
  assign PCWre   = !reset && (id_j || exe_beq || (in_mem && op_q == OP_SW && mem_ready) || in_wb);
  assign pc_src  = reset ? 2'b00 : id_j ? 2'b10 : (exe_beq && zero) ? 2'b01 : 2'b00;
  assign ir_wre  = !reset && cur == S_IF;
  assign reg_wre = !reset && in_wb;
  assign mem_rd  = !reset && in_mem && op_q == OP_LW;
  assign mem_wr  = !reset && in_mem && op_q == OP_SW;
  assign halted  = !reset && cur == S_HALT;
  assign state   = cur;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= S_IF;
      op_q        <= '0;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_ID) op_q <= opcode;
      if (PCWre) instr_count <= instr_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_multicycle_pc_sequencer.sv
// tb_multicycle_pc_sequencer: table-driven instruction walk plus HALT and reset-in-MEM sequences
module tb_multicycle_pc_sequencer;
  localparam logic [5:0] ALU = 6'b000000, LW = 6'b110001, SW = 6'b110000,
                         BEQ = 6'b110100, JMP = 6'b111000, HLT = 6'b111111;
  logic clk = 0, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic PCWre, ir_wre, reg_wre, mem_rd, mem_wr, halted;
  logic [1:0] pc_src;
  logic [2:0] state;
  logic [31:0] instr_count;
  int checks = 0, failures = 0;

  multicycle_pc_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWre(PCWre), .pc_src(pc_src), .ir_wre(ir_wre), .reg_wre(reg_wre),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic z, rdy;
    logic [2:0] st;
    logic pcw;
    logic [1:0] src;
    logic ir, rw, rd, wr;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic [5:0] op, logic z, logic rdy, logic [2:0] st, logic pcw,
                              logic [1:0] src, logic ir, logic rw, logic rd, logic wr, int cnt);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.pcw = pcw; v.src = src;
    v.ir = ir; v.rw = rw; v.rd = rd; v.wr = wr; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(logic rst, logic [5:0] op, logic z, logic rdy);
    @(negedge clk);
    reset = rst; opcode = op; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic outs(string tag, logic [2:0] st, logic pcw, logic [1:0] src, logic ir,
                      logic rw, logic rd, logic wr, logic hlt, int cnt);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".PCWre"}, 32'(PCWre), 32'(pcw));
    chk({tag, ".pc_src"}, 32'(pc_src), 32'(src));
    chk({tag, ".ir_wre"}, 32'(ir_wre), 32'(ir));
    chk({tag, ".reg_wre"}, 32'(reg_wre), 32'(rw));
    chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(rd));
    chk({tag, ".mem_wr"}, 32'(mem_wr), 32'(wr));
    chk({tag, ".halted"}, 32'(halted), 32'(hlt));
    chk({tag, ".count"}, instr_count, 32'(cnt));
  endtask

  task automatic quiet(string tag);
    chk({tag, ".PCWre"}, 32'(PCWre), 0);
    chk({tag, ".pc_src"}, 32'(pc_src), 0);
    chk({tag, ".ir_wre"}, 32'(ir_wre), 0);
    chk({tag, ".reg_wre"}, 32'(reg_wre), 0);
    chk({tag, ".mem_rd"}, 32'(mem_rd), 0);
    chk({tag, ".mem_wr"}, 32'(mem_wr), 0);
    chk({tag, ".halted"}, 32'(halted), 0);
  endtask

  initial begin
    // ALU: IF ID EXE WB (zero in EXE must be ignored)
    tbl.push_back(mk(ALU, 0, 1, 3'd0, 0, 2'b00, 1, 0, 0, 0, 0));
    tbl.push_back(mk(ALU, 0, 1, 3'd1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(ALU, 1, 1, 3'd2, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(ALU, 0, 1, 3'd4, 1, 2'b00, 0, 1, 0, 0, 0));
    // LW with two not-ready MEM cycles
    tbl.push_back(mk(LW, 0, 1, 3'd0, 0, 2'b00, 1, 0, 0, 0, 1));
    tbl.push_back(mk(LW, 0, 1, 3'd1, 0, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(LW, 0, 1, 3'd2, 0, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(LW, 0, 0, 3'd3, 0, 2'b00, 0, 0, 1, 0, 1));
    tbl.push_back(mk(LW, 0, 0, 3'd3, 0, 2'b00, 0, 0, 1, 0, 1));
    tbl.push_back(mk(LW, 0, 1, 3'd3, 0, 2'b00, 0, 0, 1, 0, 1));
    tbl.push_back(mk(LW, 0, 1, 3'd4, 1, 2'b00, 0, 1, 0, 0, 1));
    // BEQ taken, then not taken
    tbl.push_back(mk(BEQ, 0, 1, 3'd0, 0, 2'b00, 1, 0, 0, 0, 2));
    tbl.push_back(mk(BEQ, 0, 1, 3'd1, 0, 2'b00, 0, 0, 0, 0, 2));
    tbl.push_back(mk(BEQ, 1, 1, 3'd2, 1, 2'b01, 0, 0, 0, 0, 2));
    tbl.push_back(mk(BEQ, 1, 1, 3'd0, 0, 2'b00, 1, 0, 0, 0, 3));
    tbl.push_back(mk(BEQ, 1, 1, 3'd1, 0, 2'b00, 0, 0, 0, 0, 3));
    tbl.push_back(mk(BEQ, 0, 1, 3'd2, 1, 2'b00, 0, 0, 0, 0, 3));
    // J retires in ID
    tbl.push_back(mk(JMP, 1, 1, 3'd0, 0, 2'b00, 1, 0, 0, 0, 4));
    tbl.push_back(mk(JMP, 1, 1, 3'd1, 1, 2'b10, 0, 0, 0, 0, 4));
    // SW with one not-ready MEM cycle
    tbl.push_back(mk(SW, 0, 1, 3'd0, 0, 2'b00, 1, 0, 0, 0, 5));
    tbl.push_back(mk(SW, 0, 1, 3'd1, 0, 2'b00, 0, 0, 0, 0, 5));
    tbl.push_back(mk(SW, 0, 1, 3'd2, 0, 2'b00, 0, 0, 0, 0, 5));
    tbl.push_back(mk(SW, 0, 0, 3'd3, 0, 2'b00, 0, 0, 0, 1, 5));
    tbl.push_back(mk(SW, 0, 1, 3'd3, 1, 2'b00, 0, 0, 0, 1, 5));

    reset = 1; opcode = ALU; zero = 0; mem_ready = 0;
    step(1, ALU, 0, 0);
    quiet("rst0");
    step(1, ALU, 1, 1);
    quiet("rst1");
    chk("rst1.state", 32'(state), 0);
    chk("rst1.count", instr_count, 0);

    foreach (tbl[i]) begin
      step(0, tbl[i].op, tbl[i].z, tbl[i].rdy);
      outs($sformatf("row%0d", i), tbl[i].st, tbl[i].pcw, tbl[i].src, tbl[i].ir,
           tbl[i].rw, tbl[i].rd, tbl[i].wr, 0, tbl[i].cnt);
    end

    // HALT: frozen count, ignores zero/mem_ready until reset
    step(0, HLT, 0, 1);
    outs("halt.if", 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 6);
    step(0, HLT, 0, 1);
    outs("halt.id", 3'd1, 0, 2'b00, 0, 0, 0, 0, 0, 6);
    for (int i = 0; i < 20; i++) begin
      step(0, i[0] ? JMP : ALU, i[1], i[0]);
      outs($sformatf("halt%0d", i), 3'd5, 0, 2'b00, 0, 0, 0, 0, 1, 6);
    end
    step(1, HLT, 0, 0);
    quiet("halt.rst");
    step(0, SW, 0, 0);
    outs("halt.out", 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 0);

    // SW interrupted by reset while stalled in MEM
    step(0, SW, 0, 0);
    outs("swr.id", 3'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, SW, 0, 0);
    outs("swr.exe", 3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, SW, 0, 0);
    outs("swr.mem0", 3'd3, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(0, SW, 0, 0);
    outs("swr.mem1", 3'd3, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(1, SW, 0, 1);
    quiet("swr.rst");
    step(0, SW, 0, 1);
    outs("swr.after", 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
